// File: rtl/processor_boot_controller_pkg.sv
// processor_boot_controller_pkg: shared state encoding and sizes for the boot controller
package processor_boot_controller_pkg;
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } boot_state_e;
  localparam int REG_COUNT          = 64;
  localparam int REG_ADDR_WIDTH     = 6;
  localparam int WORD_WIDTH         = 32;
  localparam int DEFAULT_IMEM_DEPTH = 256;
endpackage

// File: rtl/processor_boot_controller.sv
// processor_boot_controller: clears the register file, loads a host program, then runs the processor until halted
module processor_boot_controller
  import processor_boot_controller_pkg::*;
#(
  parameter int IMEM_DEPTH      = DEFAULT_IMEM_DEPTH,
  parameter int IMEM_ADDR_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic [WORD_WIDTH-1:0]       host_data,
  input  logic                        host_last,
  input  logic                        host_halt,
  output logic                        imem_write_enable,
  output logic [IMEM_ADDR_WIDTH-1:0]  imem_write_address,
  output logic [WORD_WIDTH-1:0]       imem_write_data,
  output logic                        processor_reset,
  input  logic [REG_ADDR_WIDTH-1:0]   proc_rf_write_address,
  input  logic [WORD_WIDTH-1:0]       proc_rf_write_value,
  input  logic                        proc_rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]   register_file_write_address,
  output logic [WORD_WIDTH-1:0]       register_file_write_value,
  output logic                        register_file_write_enable,
  output logic                        running,
  output logic [IMEM_ADDR_WIDTH:0]    load_count,
  output logic                        overflow
);
  localparam logic [IMEM_ADDR_WIDTH:0] DEPTH_COUNT = (IMEM_ADDR_WIDTH + 1)'(IMEM_DEPTH);
  boot_state_e                 state, next_state;
  logic [REG_ADDR_WIDTH-1:0]   clear_count;
  logic                        transfer, full, halt;
  // Handshake, write-port mux and next-state selection
  always_comb begin
    host_ready                  = state == LOAD;
    transfer                    = host_valid & host_ready;
    full                        = load_count == DEPTH_COUNT;
    halt                        = (state == RUN) & host_halt;
    imem_write_enable           = transfer & ~full;
    imem_write_address          = load_count[IMEM_ADDR_WIDTH-1:0];
    imem_write_data             = host_data;
    register_file_write_enable  = (state == CLEAR) | ((state == RUN) & proc_rf_write_enable);
    register_file_write_address = state == CLEAR ? clear_count : proc_rf_write_address;
    register_file_write_value   = state == RUN ? proc_rf_write_value : '0;
    next_state = state == CLEAR ? (&clear_count ? LOAD : CLEAR) :
                 state == LOAD  ? (transfer & host_last ? RUN : LOAD) :
                 state == RUN   ? (host_halt ? CLEAR : RUN) : CLEAR;
  end
  // State, counters and registered processor controls; a halt re-arms the counters for the next CLEAR
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= CLEAR;
      clear_count     <= '0;
      load_count      <= '0;
      overflow        <= 1'b0;
      processor_reset <= 1'b1;
      running         <= 1'b0;
    end else begin
      state           <= next_state;
      processor_reset <= next_state != RUN;
      running         <= next_state == RUN;
      clear_count     <= state == CLEAR ? clear_count + REG_ADDR_WIDTH'(1) : '0;
      load_count      <= halt ? '0 : load_count + (IMEM_ADDR_WIDTH + 1)'(imem_write_enable);
      overflow        <= ~halt & (overflow | (transfer & full));
    end
  end
endmodule

// File: tb/tb_processor_boot_controller.sv
// tb_processor_boot_controller: randomized bring-up scenarios checked against a sequence-level model
module tb_processor_boot_controller;
  logic        clock = 1'b0;
  logic        reset_n, host_valid, host_last, host_halt, proc_rf_write_enable;
  logic [31:0] host_data, proc_rf_write_value;
  logic [5:0]  proc_rf_write_address;
  logic        host_ready, imem_write_enable, processor_reset, register_file_write_enable, running, overflow;
  logic [7:0]  imem_write_address;
  logic [31:0] imem_write_data, register_file_write_value;
  logic [5:0]  register_file_write_address;
  logic [8:0]  load_count;
  logic        b_host_ready, b_imem_write_enable, b_processor_reset, b_register_file_write_enable, b_running, b_overflow;
  logic [1:0]  b_imem_write_address;
  logic [31:0] b_imem_write_data, b_register_file_write_value;
  logic [5:0]  b_register_file_write_address;
  logic [2:0]  b_load_count;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] prog[$];

  always #5 clock = ~clock;

  processor_boot_controller dut (
    .clock(clock), .reset_n(reset_n), .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .host_last(host_last), .host_halt(host_halt),
    .imem_write_enable(imem_write_enable), .imem_write_address(imem_write_address),
    .imem_write_data(imem_write_data), .processor_reset(processor_reset),
    .proc_rf_write_address(proc_rf_write_address), .proc_rf_write_value(proc_rf_write_value),
    .proc_rf_write_enable(proc_rf_write_enable),
    .register_file_write_address(register_file_write_address),
    .register_file_write_value(register_file_write_value),
    .register_file_write_enable(register_file_write_enable),
    .running(running), .load_count(load_count), .overflow(overflow)
  );

  processor_boot_controller #(.IMEM_DEPTH(4), .IMEM_ADDR_WIDTH(2)) dut_small (
    .clock(clock), .reset_n(reset_n), .host_valid(host_valid), .host_ready(b_host_ready),
    .host_data(host_data), .host_last(host_last), .host_halt(host_halt),
    .imem_write_enable(b_imem_write_enable), .imem_write_address(b_imem_write_address),
    .imem_write_data(b_imem_write_data), .processor_reset(b_processor_reset),
    .proc_rf_write_address(proc_rf_write_address), .proc_rf_write_value(proc_rf_write_value),
    .proc_rf_write_enable(proc_rf_write_enable),
    .register_file_write_address(b_register_file_write_address),
    .register_file_write_value(b_register_file_write_value),
    .register_file_write_enable(b_register_file_write_enable),
    .running(b_running), .load_count(b_load_count), .overflow(b_overflow)
  );

  task automatic drive_idle();
    host_valid = 0; host_last = 0; host_halt = 0; host_data = 0;
    proc_rf_write_enable = 0; proc_rf_write_address = 0; proc_rf_write_value = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    drive_idle();
    #12;
    checks++;
    if ({host_ready, imem_write_enable, processor_reset, running, overflow} !== 5'b00100 || load_count !== 9'd0) begin
      failures++;
      $display("FAIL reset_state ctl=%b load_count=%0d required ctl=00100 load_count=0",
               {host_ready, imem_write_enable, processor_reset, running, overflow}, load_count);
    end
    checks++;
    if ({b_host_ready, b_processor_reset, b_running, b_overflow} !== 4'b0100 || b_load_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_state_small ctl=%b load_count=%0d required ctl=0100 load_count=0",
               {b_host_ready, b_processor_reset, b_running, b_overflow}, b_load_count);
    end
    @(negedge clock);
    reset_n = 1;
  endtask

  // Entered at the negedge of the first CLEAR cycle; returns at a negedge inside LOAD.
  task automatic check_clear_sequence(input string tag);
    for (int i = 0; i < 64; i++) begin
      host_valid = 1'($urandom_range(0, 1)); host_data = $urandom; host_last = 1'($urandom_range(0, 1));
      host_halt = 1'($urandom_range(0, 1));
      proc_rf_write_enable = 1; proc_rf_write_address = 6'($urandom); proc_rf_write_value = $urandom;
      #1;
      checks++;
      if ({register_file_write_enable, register_file_write_address, register_file_write_value} !== {1'b1, 6'(i), 32'h0} ||
          {host_ready, imem_write_enable, processor_reset, running} !== 4'b0010) begin
        failures++;
        $display("FAIL %s_clear[%0d] rf=%b/%0d/%h ctl=%b required rf=1/%0d/00000000 ctl=0010", tag, i,
                 register_file_write_enable, register_file_write_address, register_file_write_value,
                 {host_ready, imem_write_enable, processor_reset, running}, i);
      end
      checks++;
      if ({b_register_file_write_enable, b_register_file_write_address, b_register_file_write_value} !== {1'b1, 6'(i), 32'h0} ||
          {b_host_ready, b_processor_reset} !== 2'b01) begin
        failures++;
        $display("FAIL %s_clear_small[%0d] rf=%b/%0d/%h ready/preset=%b required rf=1/%0d/00000000 ready/preset=01", tag, i,
                 b_register_file_write_enable, b_register_file_write_address, b_register_file_write_value,
                 {b_host_ready, b_processor_reset}, i);
      end
      @(negedge clock);
    end
    drive_idle();
    proc_rf_write_enable = 1;
    #1;
    checks++;
    if ({host_ready, register_file_write_enable, processor_reset, running} !== 4'b1010) begin
      failures++;
      $display("FAIL %s_load_entry ready/rfwe/preset/running=%b required 1010", tag,
               {host_ready, register_file_write_enable, processor_reset, running});
    end
    @(negedge clock);
  endtask

  // Streams prog[] with optional valid gaps; expects the k-th word at address k while k < depth.
  task automatic load_program(input string tag, input bit gaps);
    int n = prog.size();
    int k = 0;
    int idle = 0;
    bit v, exp_we, exp_bwe;
    while (k < n) begin
      v = gaps ? ($urandom_range(0, 2) != 0 || idle >= 2) : 1'b1;
      host_valid = v;
      host_data = v ? prog[k] : $urandom;
      host_last = v ? (k == n - 1) : 1'($urandom_range(0, 1));
      host_halt = 1'($urandom_range(0, 1));
      proc_rf_write_enable = 1; proc_rf_write_address = 6'($urandom); proc_rf_write_value = $urandom;
      #1;
      exp_we = v && k < 256;
      exp_bwe = v && k < 4;
      checks++;
      if ({host_ready, imem_write_enable, register_file_write_enable, processor_reset} !== {1'b1, exp_we, 1'b0, 1'b1} ||
          (exp_we && (imem_write_address !== 8'(k) || imem_write_data !== prog[k]))) begin
        failures++;
        $display("FAIL %s_word[%0d] ready/we/rfwe/preset=%b addr=%0d data=%h required %b addr=%0d data=%h", tag, k,
                 {host_ready, imem_write_enable, register_file_write_enable, processor_reset}, imem_write_address,
                 imem_write_data, {1'b1, exp_we, 1'b0, 1'b1}, k, prog[k]);
      end
      checks++;
      if ({b_host_ready, b_imem_write_enable} !== {1'b1, exp_bwe} ||
          (exp_bwe && (b_imem_write_address !== 2'(k) || b_imem_write_data !== prog[k]))) begin
        failures++;
        $display("FAIL %s_word_small[%0d] ready/we=%b addr=%0d data=%h required %b addr=%0d data=%h", tag, k,
                 {b_host_ready, b_imem_write_enable}, b_imem_write_address, b_imem_write_data,
                 {1'b1, exp_bwe}, k % 4, prog[k]);
      end
      if (v) begin k++; idle = 0; end else idle++;
      @(negedge clock);
    end
    drive_idle();
    #1;
    checks++;
    if ({running, processor_reset, host_ready} !== 3'b100 || load_count !== 9'(n < 256 ? n : 256) || overflow !== (n > 256)) begin
      failures++;
      $display("FAIL %s_run_entry run/preset/ready=%b load_count=%0d overflow=%b required 100 load_count=%0d overflow=%b",
               tag, {running, processor_reset, host_ready}, load_count, overflow, n < 256 ? n : 256, n > 256);
    end
    checks++;
    if ({b_running, b_processor_reset} !== 2'b10 || b_load_count !== 3'(n < 4 ? n : 4) || b_overflow !== (n > 4)) begin
      failures++;
      $display("FAIL %s_run_entry_small run/preset=%b load_count=%0d overflow=%b required 10 load_count=%0d overflow=%b",
               tag, {b_running, b_processor_reset}, b_load_count, b_overflow, n < 4 ? n : 4, n > 4);
    end
    @(negedge clock);
  endtask

  task automatic test_run_passthrough(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      host_valid = 1'($urandom_range(0, 1)); host_data = $urandom; host_last = 1'($urandom_range(0, 1)); host_halt = 0;
      proc_rf_write_enable = 1'($urandom_range(0, 1));
      proc_rf_write_address = i == 0 ? 6'd3 : 6'($urandom);
      proc_rf_write_value = i == 0 ? 32'hC : $urandom;
      if (i == 0) proc_rf_write_enable = 1;
      #1;
      checks++;
      if ({register_file_write_enable, register_file_write_address, register_file_write_value} !==
          {proc_rf_write_enable, proc_rf_write_address, proc_rf_write_value} ||
          {host_ready, imem_write_enable, running, processor_reset} !== 4'b0010) begin
        failures++;
        $display("FAIL %s_pass[%0d] rf=%b/%0d/%h ctl=%b required rf=%b/%0d/%h ctl=0010", tag, i,
                 register_file_write_enable, register_file_write_address, register_file_write_value,
                 {host_ready, imem_write_enable, running, processor_reset},
                 proc_rf_write_enable, proc_rf_write_address, proc_rf_write_value);
      end
      checks++;
      if ({b_register_file_write_enable, b_register_file_write_value} !== {proc_rf_write_enable, proc_rf_write_value} ||
          {b_host_ready, b_imem_write_enable, b_running} !== 3'b001) begin
        failures++;
        $display("FAIL %s_pass_small[%0d] rf=%b/%h ctl=%b required rf=%b/%h ctl=001", tag, i,
                 b_register_file_write_enable, b_register_file_write_value,
                 {b_host_ready, b_imem_write_enable, b_running}, proc_rf_write_enable, proc_rf_write_value);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_halt(input string tag);
    host_valid = 0; host_halt = 1;
    proc_rf_write_enable = 1; proc_rf_write_address = 6'($urandom); proc_rf_write_value = $urandom;
    #1;
    checks++;
    if ({register_file_write_enable, register_file_write_address, register_file_write_value} !==
        {1'b1, proc_rf_write_address, proc_rf_write_value} || running !== 1'b1) begin
      failures++;
      $display("FAIL %s_halt_cycle rf=%b/%0d/%h running=%b required rf=1/%0d/%h running=1", tag,
               register_file_write_enable, register_file_write_address, register_file_write_value, running,
               proc_rf_write_address, proc_rf_write_value);
    end
    @(negedge clock);
    host_halt = 0;
    proc_rf_write_address = 6'd40; proc_rf_write_value = 32'hDEADBEEF;
    #1;
    checks++;
    if ({processor_reset, running, overflow, b_overflow} !== 4'b1000 || load_count !== 9'd0 || b_load_count !== 3'd0 ||
        register_file_write_value !== 32'h0 || register_file_write_address !== 6'd0) begin
      failures++;
      $display("FAIL %s_after_halt preset/run/ovf/ovf_s=%b load_count=%0d/%0d rf=%0d/%h required 1000 0/0 rf=0/00000000", tag,
               {processor_reset, running, overflow, b_overflow}, load_count, b_load_count,
               register_file_write_address, register_file_write_value);
    end
    check_clear_sequence(tag);
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 2; i++) begin
      host_valid = 1; host_data = $urandom; host_last = 0;
      @(negedge clock);
    end
    host_valid = 1; host_data = $urandom;
    #1;
    checks++;
    if (load_count !== 9'd2 || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL midload_before load_count=%0d ready=%b required 2 1", load_count, host_ready);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if ({host_ready, imem_write_enable, processor_reset, running} !== 4'b0010 || load_count !== 9'd0 ||
        register_file_write_enable !== 1'b1) begin
      failures++;
      $display("FAIL midload_reset ready/we/preset/run=%b load_count=%0d rfwe=%b required 0010 0 1",
               {host_ready, imem_write_enable, processor_reset, running}, load_count, register_file_write_enable);
    end
    @(negedge clock);
    reset_n = 1;
    check_clear_sequence("midload");
  endtask

  initial begin
    test_reset();
    check_clear_sequence("por");
    prog = '{32'h24010005, 32'h24020007, 32'h00221820};
    load_program("basic", 1);
    test_run_passthrough("basic", 6);
    test_halt("basic");
    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back($urandom);
    load_program("six", 1);
    test_run_passthrough("six", 3);
    test_halt("six");
    for (int r = 0; r < 3; r++) begin
      prog.delete();
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) prog.push_back($urandom);
      load_program($sformatf("rand%0d", r), 1);
      test_run_passthrough($sformatf("rand%0d", r), 4);
      test_halt($sformatf("rand%0d", r));
    end
    test_reset_mid_load();
    prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load_program("post_reset", 0);
    test_run_passthrough("post_reset", 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
